// File: rtl/jtframe_nvram_pkg.sv
// Shared types and defaults for the NVRAM dump block.
package jtframe_nvram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_IO    = 2'd2
  } nvram_st_t;

  localparam logic [7:0] NVRAM_FILL = 8'hFF;

endpackage

// File: rtl/jtframe_nvram_dpram.sv
// Single-clock, single-port 2^AW x 8 RAM with a registered read port.
// A read during a write to the same address returns the old byte.
module jtframe_nvram_dpram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_din,
  input  logic          i_we,
  output logic [7:0]    o_dout
);

  logic [7:0] r_mem [2**AW];
  logic [7:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dout <= '0;
    else     r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/jtframe_nvram_dump.sv
// NVRAM shared between the game core and the ioctl load/dump channel.
// Optional power-up fill with FILL is built when JTFRAME_NVRAM_CLEAR_EN is defined.
module jtframe_nvram_dump
  import jtframe_nvram_pkg::*;
#(
  parameter int unsigned AW   = 12,
  parameter logic [7:0]  FILL = NVRAM_FILL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] game_addr,
  input  logic [7:0]    game_din,
  input  logic          game_we,
  output logic [7:0]    game_dout,
  output logic          game_ok,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  input  logic          ioctl_ram,
  output logic [7:0]    ioctl_data_out,
  output logic          dirty,
  output logic          busy
);

  nvram_st_t     r_st, w_st_nx;
  logic          r_game_ok, r_dirty, r_oor;
  logic          w_ioctl_in;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_din, w_q;
  logic          w_we;

`ifdef JTFRAME_NVRAM_CLEAR_EN
  logic [AW-1:0] r_clr_cnt;
`endif

  assign w_ioctl_in = (ioctl_addr[24:AW] == '0);

  always_comb begin
    w_st_nx = r_st;
    w_addr  = game_addr;
    w_din   = game_din;
    w_we    = 1'b0;
    case (r_st)
      ST_RUN: begin
        w_we = game_we;
        if (ioctl_ram) w_st_nx = ST_IO;
      end
      ST_IO: begin
        w_addr = ioctl_addr[AW-1:0];
        w_din  = ioctl_data;
        w_we   = ioctl_wr & w_ioctl_in;
        if (!ioctl_ram) w_st_nx = ST_RUN;
      end
`ifdef JTFRAME_NVRAM_CLEAR_EN
      ST_CLEAR: begin
        // A load arriving mid-clear takes the port in that same cycle so
        // the clear can never touch loaded data.
        if (ioctl_ram) begin
          w_addr  = ioctl_addr[AW-1:0];
          w_din   = ioctl_data;
          w_we    = ioctl_wr & w_ioctl_in;
          w_st_nx = ST_IO;
        end else begin
          w_addr = r_clr_cnt;
          w_din  = FILL;
          w_we   = 1'b1;
          if (&r_clr_cnt) w_st_nx = ST_RUN;
        end
      end
`endif
      default: w_st_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef JTFRAME_NVRAM_CLEAR_EN
      r_st      <= ST_CLEAR;
      r_clr_cnt <= '0;
`else
      r_st      <= ST_RUN;
`endif
      r_game_ok <= 1'b0;
      r_dirty   <= 1'b0;
      r_oor     <= 1'b0;
    end else begin
      r_st      <= w_st_nx;
`ifdef JTFRAME_NVRAM_CLEAR_EN
      if (r_st == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
`endif
      r_game_ok <= (r_st == ST_RUN);
      r_oor     <= ~w_ioctl_in;
      if (r_st == ST_RUN && game_we)      r_dirty <= 1'b1;
      else if (r_st == ST_IO && !ioctl_ram) r_dirty <= 1'b0;
    end
  end

  jtframe_nvram_dpram #(.AW(AW)) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_addr),
    .i_din  (w_din),
    .i_we   (w_we),
    .o_dout (w_q)
  );

  assign game_dout      = w_q;
  assign ioctl_data_out = r_oor ? FILL : w_q;
  assign game_ok        = r_game_ok;
  assign dirty          = r_dirty;

`ifdef JTFRAME_NVRAM_CLEAR_EN
  assign busy = (r_st == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_nvram_dump.sv
// Directed self-checking bench for jtframe_nvram_dump with AW=4.
// Covers the JTFRAME_NVRAM_CLEAR_EN build when that macro is defined.
module tb_jtframe_nvram_dump;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] game_addr;
  logic [7:0]    game_din;
  logic          game_we;
  logic [7:0]    game_dout;
  logic          game_ok;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          ioctl_ram;
  logic [7:0]    ioctl_data_out;
  logic          dirty;
  logic          busy;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] exp_mem [16];

  always #5 clk = ~clk;

  jtframe_nvram_dump #(.AW(AW), .FILL(8'hFF)) dut (
    .clk            (clk),
    .rst            (rst),
    .game_addr      (game_addr),
    .game_din       (game_din),
    .game_we        (game_we),
    .game_dout      (game_dout),
    .game_ok        (game_ok),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_ram      (ioctl_ram),
    .ioctl_data_out (ioctl_data_out),
    .dirty          (dirty),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic game_wr(input int unsigned a, input logic [7:0] d);
    game_addr = AW'(a);
    game_din  = d;
    game_we   = 1'b1;
    step();
    game_we    = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic game_rd(input int unsigned a, input string tag);
    game_addr = AW'(a);
    step();
    check(tag, {24'd0, game_dout}, {24'd0, exp_mem[a]});
  endtask

  task automatic io_rd(input logic [24:0] a, input logic [7:0] want, input string tag);
    ioctl_addr = a;
    step();
    check(tag, {24'd0, ioctl_data_out}, {24'd0, want});
  endtask

  initial begin
    int n;
    rst = 1'b1; game_addr = '0; game_din = '0; game_we = 1'b0;
    ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0; ioctl_ram = 1'b0;
    step(); step();
    check("rst_game_dout", {24'd0, game_dout}, 32'd0);
    check("rst_ioctl_out", {24'd0, ioctl_data_out}, 32'd0);
    check("rst_game_ok", {31'd0, game_ok}, 32'd0);
    check("rst_dirty", {31'd0, dirty}, 32'd0);
`ifdef JTFRAME_NVRAM_CLEAR_EN
    check("rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("clear_len", 32'(n), 32'd16);
    step();
    check("game_ok_up", {31'd0, game_ok}, 32'd1);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'hFF;
`else
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();
    check("game_ok_up", {31'd0, game_ok}, 32'd1);
    for (int i = 0; i < 16; i++) game_wr(i, 8'(i * 19 + 33));
`endif
    for (int i = 0; i < 16; i++) game_rd(i, "init_rd");

    // game write: read during write returns old data
    game_addr = 4'd3; game_din = 8'h5A; game_we = 1'b1;
    step();
    check("rdw_old", {24'd0, game_dout}, {24'd0, exp_mem[3]});
    game_we = 1'b0; exp_mem[3] = 8'h5A;
    step();
    check("game_rd3", {24'd0, game_dout}, 32'h5A);
    check("dirty_set", {31'd0, dirty}, 32'd1);

    // dump; game writes during IO must be ignored
    ioctl_ram = 1'b1;
    step();
    game_we = 1'b1; game_addr = 4'd0; game_din = 8'hEE;
    step();
    check("game_ok_io", {31'd0, game_ok}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      io_rd(25'(i), exp_mem[i], "dump");
      check("dump_game_ok", {31'd0, game_ok}, 32'd0);
    end
    ioctl_ram = 1'b0;
    step();
    game_we = 1'b0;
    check("dirty_clr", {31'd0, dirty}, 32'd0);
    check("game_ok_lag", {31'd0, game_ok}, 32'd0);
    step();
    check("game_ok_back", {31'd0, game_ok}, 32'd1);
    game_rd(0, "io_we_ignored");

    // out-of-range write dropped, read returns FILL; in-range load lands
    ioctl_ram = 1'b1;
    step(); step();
    ioctl_addr = 25'h10; ioctl_data = 8'h77; ioctl_wr = 1'b1;
    step();
    check("oor_read", {24'd0, ioctl_data_out}, 32'hFF);
    ioctl_addr = 25'h9; ioctl_data = 8'h11;
    step();
    ioctl_wr = 1'b0; exp_mem[9] = 8'h11;
    io_rd(25'h0, exp_mem[0], "oor_no_write");
    io_rd(25'h9, 8'h11, "load_rd9");
    io_rd(25'h1000009, 8'hFF, "oor_high");
    ioctl_ram = 1'b0;
    step(); step();
    game_rd(9, "game_rd9");

    // game write in the same cycle ioctl_ram rises
    game_addr = 4'd2; game_din = 8'h33; game_we = 1'b1; ioctl_ram = 1'b1;
    step();
    game_we = 1'b0; exp_mem[2] = 8'h33;
    check("simul_dirty", {31'd0, dirty}, 32'd1);
    io_rd(25'h2, 8'h33, "simul_rd2");
    ioctl_ram = 1'b0;
    step();
    check("simul_dirty_clr", {31'd0, dirty}, 32'd0);
    step();

`ifdef JTFRAME_NVRAM_CLEAR_EN
    // reset then abort the clear with a load 5 cycles in
    for (int i = 10; i < 16; i++) game_wr(i, 8'(i + 8'h40));
    rst = 1'b1;
    step();
    check("rerst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("clear_busy5", {31'd0, busy}, 32'd1);
    ioctl_ram = 1'b1; ioctl_addr = 25'h9; ioctl_data = 8'h11; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) exp_mem[i] = 8'hFF;
    for (int i = 0; i < 16; i++) io_rd(25'(i), exp_mem[i], "abort_rd");
    ioctl_ram = 1'b0;
    step(); step();
    check("abort_game_ok", {31'd0, game_ok}, 32'd1);
    game_rd(9, "abort_game9");
`else
    // reset during a transfer returns straight to RUN
    ioctl_ram = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    check("rerst_game_ok", {31'd0, game_ok}, 32'd0);
    check("rerst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; ioctl_ram = 1'b0;
    step();
    check("rerst_run", {31'd0, game_ok}, 32'd1);
    game_rd(2, "rerst_rd2");
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
